// File: rtl/ram_responder_pkg.sv
// Shared CPU/RAM interface types plus the responder's private FSM encoding.
// Both packages live together so one file brings in everything the responder needs.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

package ram_responder_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACC,
    ERR
  } fsm_state_t;

  function automatic ramstate_t to_ramstate(fsm_state_t s);
    case (s)
      IDLE:    return FREE;
      WAIT:    return BUSY;
      ACC:     return ACCESS;
      default: return ERROR;
    endcase
  endfunction
endpackage

// File: rtl/ram_responder_if.sv
// CPU-to-RAM request/response bundle; the CPU side is master, the memory side slave.
interface ram_responder_if;
  import cpu_types_pkg::*;

  word_t     memaddr;
  word_t     memstore;
  logic      memREN;
  logic      memWEN;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output memaddr, memstore, memREN, memWEN,
    input  ramload, ramstate
  );

  modport slave (
    input  memaddr, memstore, memREN, memWEN,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder_ram_array.sv
// Word storage for the responder: synchronous write, combinational read.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] widx,
  input  word_t             wdata,
  input  logic [ADDR_W-1:0] ridx,
  output word_t             rdata
);
  word_t mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (WEN) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[ridx];
endmodule

// File: rtl/ram_responder.sv
// Single-outstanding memory responder: BUSY for LAT cycles, one ACCESS cycle,
// ERROR for malformed requests. All bus outputs come straight from flops.
module ram_responder
  import cpu_types_pkg::*;
  import ram_responder_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic            CLK,
  input  logic            RST,
  ram_responder_if.slave  bus
);
  localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

  fsm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  word_t             addr_q, addr_d;
  logic              wr_q, wr_d;
  word_t             data_q, data_d;
  word_t             ramload_q, ramload_d;
  ramstate_t         ramstate_q, ramstate_d;

  logic              req_any;
  logic              illegal;
  logic              req_match;
  logic              complete;
  logic              cmp_wr;
  logic [ADDR_W-1:0] cmp_idx;
  word_t             cmp_data;
  word_t             rdata;

  assign req_any = bus.memREN | bus.memWEN;
  assign illegal = (bus.memREN & bus.memWEN) ||
                   (bus.memaddr[1:0] != 2'b00) ||
                   (bus.memaddr[31:ADDR_W+2] != '0);
  // Any change of op or address while waiting counts as a new request, not this one.
  assign req_match = (wr_q ? (bus.memWEN & ~bus.memREN) : (bus.memREN & ~bus.memWEN)) &&
                     (bus.memaddr == addr_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    data_d    = data_q;
    ramload_d = ramload_q;
    complete  = 1'b0;
    cmp_wr    = wr_q;
    cmp_idx   = addr_q[ADDR_W+1:2];
    cmp_data  = data_q;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (illegal) begin
            state_d = ERR;
          end else begin
            addr_d = bus.memaddr;
            wr_d   = bus.memWEN;
            data_d = bus.memstore;
            cnt_d  = CNT_W'(LAT);
            if (LAT == 0) begin
              // Zero latency completes from the live request on the accepting edge.
              state_d  = ACC;
              complete = 1'b1;
              cmp_wr   = bus.memWEN;
              cmp_idx  = bus.memaddr[ADDR_W+1:2];
              cmp_data = bus.memstore;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (!req_match) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = ACC;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACC:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (complete && !cmp_wr) begin
      ramload_d = rdata;
    end
    ramstate_d = to_ramstate(state_d);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ramload_q  <= '0;
      ramstate_q <= FREE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ramload_q  <= ramload_d;
      ramstate_q <= ramstate_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    wr_q   <= wr_d;
    data_q <= data_d;
  end

  ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .CLK   (CLK),
    .WEN   (complete & cmp_wr & ~RST),
    .widx  (cmp_idx),
    .wdata (cmp_data),
    .ridx  (cmp_idx),
    .rdata (rdata)
  );

  assign bus.ramload  = ramload_q;
  assign bus.ramstate = ramstate_q;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder at LAT=0/2/4; responses are scoreboarded
// by a negedge monitor, intermediate BUSY/FREE states checked inline.
module tb_ram_responder;
  import cpu_types_pkg::*;

  typedef struct {
    int        d;
    int        cyc;
    ramstate_t st;
    word_t     ld;
  } exp_t;

  logic CLK;
  logic RST;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t scb[$];

  ram_responder_if b0 ();
  ram_responder_if b1 ();
  ram_responder_if b2 ();

  ram_responder #(.LAT(0), .ADDR_W(10)) u_lat0 (.CLK(CLK), .RST(RST), .bus(b0));
  ram_responder #(.LAT(2), .ADDR_W(10)) u_lat2 (.CLK(CLK), .RST(RST), .bus(b1));
  ram_responder #(.LAT(4), .ADDR_W(10)) u_lat4 (.CLK(CLK), .RST(RST), .bus(b2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int lat_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 4);
  endfunction

  function automatic ramstate_t get_st(int d);
    case (d)
      0:       return b0.ramstate;
      1:       return b1.ramstate;
      default: return b2.ramstate;
    endcase
  endfunction

  function automatic word_t get_ld(int d);
    case (d)
      0:       return b0.ramload;
      1:       return b1.ramload;
      default: return b2.ramload;
    endcase
  endfunction

  task automatic drive(int d, logic ren, logic wen, word_t a, word_t s);
    case (d)
      0: begin b0.memREN = ren; b0.memWEN = wen; b0.memaddr = a; b0.memstore = s; end
      1: begin b1.memREN = ren; b1.memWEN = wen; b1.memaddr = a; b1.memstore = s; end
      default: begin b2.memREN = ren; b2.memWEN = wen; b2.memaddr = a; b2.memstore = s; end
    endcase
  endtask

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic chk_st(string nm, int d, ramstate_t exp);
    chk(nm, d, 32'(get_st(d)), 32'(exp));
  endtask

  task automatic push(int d, int c, ramstate_t st, word_t ld);
    exp_t e;
    e.d = d; e.cyc = c; e.st = st; e.ld = ld;
    scb.push_back(e);
  endtask

  // Holds the request until the response cycle, then drops it.
  task automatic do_req(int d, logic ren, logic wen, word_t a, word_t s,
                        ramstate_t exp_st, word_t exp_ld);
    int n;
    int c;
    n = (exp_st == ERROR) ? 1 : lat_of(d) + 1;
    @(posedge CLK); #1;
    c = cyc;
    push(d, c + n, exp_st, exp_ld);
    drive(d, ren, wen, a, s);
    for (int k = 1; k < n; k++) begin
      @(posedge CLK); #1;
      chk_st("busy", d, BUSY);
    end
    @(posedge CLK); #1;
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    chk_st("free_after", d, FREE);
  endtask

  always @(negedge CLK) begin
    exp_t      e;
    ramstate_t st;
    if (!RST) begin
      if (scb.size() > 0 && cyc > scb[0].cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_resp dut=%0d due=%0d now=%0d", scb[0].d, scb[0].cyc, cyc);
        void'(scb.pop_front());
      end
      for (int d = 0; d < 3; d++) begin
        st = get_st(d);
        if (st == ACCESS || st == ERROR) begin
          $display("txn dut=%0d cyc=%0d state=%0d ramload=%h", d, cyc, st, get_ld(d));
          if (scb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp dut=%0d cyc=%0d got=%0d want=none", d, cyc, st);
          end else begin
            e = scb.pop_front();
            chk("resp_dut", d, d, e.d);
            chk("resp_state", d, 32'(st), 32'(e.st));
            chk("resp_load", d, get_ld(d), e.ld);
            chk("resp_cycle", d, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    RST = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk_st("reset_state", d, FREE);
      chk("reset_load", d, get_ld(d), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk_st("idle_free", 2, FREE);
    end

    // LAT=2: write then read back
    do_req(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ACCESS, 32'h0);
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF);

    // LAT=0
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h12345678, ACCESS, 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'h12345678);

    // Errors on LAT=2; 0x1000 would alias word 0 if the range check were missing
    do_req(1, 1'b0, 1'b1, 32'h0, 32'h0000C0DE, ACCESS, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b1, 32'h10, 32'h0, ERROR, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b0, 32'h2, 32'h0, ERROR, 32'hDEADBEEF);
    do_req(1, 1'b0, 1'b1, 32'h1000, 32'h55555555, ERROR, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b0, 32'h10, 32'h0, ACCESS, 32'hDEADBEEF);
    do_req(1, 1'b1, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0000C0DE);
    do_req(1, 1'b0, 1'b1, 32'hFFC, 32'hA5A5F00D, ACCESS, 32'h0000C0DE);
    do_req(1, 1'b1, 1'b0, 32'hFFC, 32'h0, ACCESS, 32'hA5A5F00D);

    // Read held through ACCESS is re-accepted: second ACCESS LAT+2 later
    @(posedge CLK); #1;
    c = cyc;
    push(1, c + 3, ACCESS, 32'hA5A5F00D);
    push(1, c + 7, ACCESS, 32'hA5A5F00D);
    drive(1, 1'b1, 1'b0, 32'hFFC, 32'h0);
    repeat (4) @(posedge CLK);
    #1 chk_st("held_free", 1, FREE);
    repeat (3) @(posedge CLK);
    #1 drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    chk_st("held_free2", 1, FREE);

    // LAT=4: abort by changing memaddr mid-wait
    do_req(2, 1'b0, 1'b1, 32'h20, 32'hCAFE0020, ACCESS, 32'h0);
    @(posedge CLK); #1;
    drive(2, 1'b0, 1'b1, 32'h20, 32'h00001111);
    @(posedge CLK); #1;
    chk_st("abort_busy1", 2, BUSY);
    @(posedge CLK); #1;
    chk_st("abort_busy2", 2, BUSY);
    drive(2, 1'b0, 1'b1, 32'h24, 32'h00001111);
    @(posedge CLK); #1;
    chk_st("abort_free", 2, FREE);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    chk_st("abort_idle", 2, FREE);
    do_req(2, 1'b1, 1'b0, 32'h20, 32'h0, ACCESS, 32'hCAFE0020);

    // LAT=4: reset during BUSY of a write abandons it
    do_req(2, 1'b0, 1'b1, 32'h30, 32'h3030A5A5, ACCESS, 32'hCAFE0020);
    @(posedge CLK); #1;
    drive(2, 1'b0, 1'b1, 32'h30, 32'h00000BAD);
    @(posedge CLK); #1;
    chk_st("rst_busy1", 2, BUSY);
    @(posedge CLK); #1;
    chk_st("rst_busy2", 2, BUSY);
    RST = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_st("rst_free", 2, FREE);
    chk("rst_load", 2, get_ld(2), 32'h0);
    do_req(2, 1'b1, 1'b0, 32'h30, 32'h0, ACCESS, 32'h3030A5A5);

    repeat (3) @(posedge CLK);
    #1 chk("scb_empty", 0, scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
# ram_responder

Word-addressed memory responder for the RAM end of the CPU–RAM interface. It stands in for main memory below the memory controller in single-core and multi-core simulation. It accepts one read or write request at a time, holds the requester off with BUSY for a configurable number of cycles, then completes it with a single ACCESS cycle. It reports ERROR for illegal requests.

## Interface
- LAT, 2: number of BUSY cycles before ACCESS (0 allowed).
- ADDR_W, 10: word-index width; the memory holds 2^ADDR_W 32-bit words.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- memaddr  in  32  byte address; [1:0] must be 0; [ADDR_W+1:2] is the word index.
- memstore  in  32  write data.
- memREN  in  1  read request, level.
- memWEN  in  1  write request, level.
- ramload  out  32  read data; valid during ACCESS of a read.
- ramstate  out  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- FSM states: IDLE, WAIT, ACC, ERR. Outputs are registered.
- ramstate mapping: IDLE→FREE, WAIT→BUSY, ACC→ACCESS, ERR→ERROR.
- Reset: state=IDLE, cnt=0, ramload=0, ramstate=FREE.
  - Storage contents are not reset.
  - A reset during WAIT abandons the request with no write.
- IDLE, no request: stay in IDLE.
- IDLE, illegal request → ERR. Illegal means any of:
  - memREN and memWEN both high;
  - memaddr[1:0]≠0;
  - memaddr[31:ADDR_W+2]≠0.
- IDLE, legal request:
  - capture addr, op, data; cnt←LAT;
  - go to WAIT if LAT>0, otherwise go directly to ACC and complete as below.
- WAIT, abort condition → IDLE. Abort means the request is dropped, or the op or memaddr differs from the captured value.
  - No write occurs.
  - The new request is not accepted on that same edge.
- WAIT, request still matches:
  - cnt==1 → ACC and complete;
  - otherwise cnt←cnt−1.
- Completion, on the edge entering ACC:
  - write: array[idx]←captured data; ramload unchanged;
  - read: ramload←array[idx].
- ACC → IDLE unconditionally, after exactly one cycle.
- ERR → IDLE unconditionally, after exactly one cycle. Storage and ramload are unchanged.
- Only one request is outstanding at a time.
- Read-after-write: a read of an address written by an earlier completed write returns the new data.

## Timing
- The request is first high in cycle 0.
- For LAT>0: BUSY is shown in cycles 1..LAT and ACCESS in cycle LAT+1.
- For LAT=0: ACCESS is shown in cycle 1.
- ramload is valid throughout the ACCESS cycle and holds its value until the next read completion.
- The state after ACC or ERR is always FREE for at least one cycle. The earliest next ACCESS is LAT+2 cycles after ACC.
- A request still held during the ACC cycle is accepted again from IDLE in the following cycle.
  - Reads repeat harmlessly.
  - Writes rewrite the same data.
- Illegal request in cycle 0 → ERROR in cycle 1 → FREE in cycle 2.
- cnt is wide enough to hold LAT. No wrap-around occurs.

## Structure
- Shared package cpu_types_pkg holds:
  - word_t (32-bit);
  - ramstate_t enum {FREE, BUSY, ACCESS, ERROR}.
- ram_responder imports both types from that package.
- Sub-module ram_array holds the storage. Its ports are CLK, WEN, widx, wdata, ridx and rdata.
  - 2^ADDR_W × 32 storage.
  - Synchronous write; combinational read.
  - The responder registers the read result into ramload.

## Test plan
- Reset, then idle: with RST high for 2 cycles, ramstate=FREE and ramload=0; ramstate stays FREE while REN=WEN=0.
- Write then read, LAT=2:
  - WEN with memaddr=0x10 and memstore=0xDEADBEEF → BUSY in cycles 1–2, ACCESS in cycle 3;
  - then REN with memaddr=0x10 → ACCESS 3 cycles after request, with ramload=0xDEADBEEF.
- LAT=0: REN with memaddr=0x10 → ACCESS in cycle 1 with the stored data.
- Abort mid-wait, LAT=4:
  - WEN to 0x20 with data 0x1111, memaddr changed to 0x24 in cycle 2 → FREE in cycle 3;
  - a later read of 0x20 returns the old contents.
- Errors:
  - REN=WEN=1 → ERROR for 1 cycle, then FREE;
  - memaddr=0x2 → ERROR;
  - memaddr=0x1000 with ADDR_W=10 → ERROR;
  - in all three cases storage and ramload are unchanged.
- Reset mid-request: RST asserted during BUSY of a write to 0x30 → FREE the next cycle; 0x30 is not written.
